fini_vote_register: RTL

- Registered correction stage directly downstream of the triplicated FINI multiplier/majority-correction datapath.
- Accepts the three redundant copies of the multiplier result and votes them bitwise by majority.
- Re-emits the corrected value replicated into three copies on a valid/ready register slice.
- Counts fault-affected words and escalates to an alarm state that halts intake until explicitly cleared.

---
 rtl/fini_vote_register_if.sv | 34 +++
 rtl/fini_vote_register.sv | 104 ++++++++++
 2 files changed

// File: rtl/fini_vote_register_if.sv
// ============================================================================
//  fini_vote_register_if
//  Handshake and status bundle for the FINI majority-vote register stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface fini_vote_register_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3*WIDTH-1:0]   port_c_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [3*WIDTH-1:0]   port_c_out;
   logic                 out_fault;
   logic [CNT_W-1:0]     fault_cnt;
   logic                 alarm;
   logic                 clear_alarm;

   modport slave (
      input  in_valid, port_c_in, out_ready, clear_alarm,
      output in_ready, out_valid, port_c_out, out_fault, fault_cnt, alarm
   );

   modport master (
      output in_valid, port_c_in, out_ready, clear_alarm,
      input  in_ready, out_valid, port_c_out, out_fault, fault_cnt, alarm
   );
endinterface

`default_nettype wire

// File: rtl/fini_vote_register.sv
// ============================================================================
//  fini_vote_register
//  Bitwise majority vote of three redundant copies into a valid/ready register
//  slice, with saturating fault counting and a latched alarm state.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fini_vote_register #(
   parameter int WIDTH        = 1,
   parameter int CNT_W        = 4,
   parameter int ALARM_THRESH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   fini_vote_register_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      ALARM = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nx;

   logic [WIDTH-1:0]     c0;
   logic [WIDTH-1:0]     c1;
   logic [WIDTH-1:0]     c2;
   logic [WIDTH-1:0]     vote;
   logic                 fault;
   logic                 ready;
   logic                 acc;

   logic                 valid_q;
   logic [3*WIDTH-1:0]   data_q;
   logic                 fault_q;

   assign c0    = bus.port_c_in[0*WIDTH +: WIDTH];
   assign c1    = bus.port_c_in[1*WIDTH +: WIDTH];
   assign c2    = bus.port_c_in[2*WIDTH +: WIDTH];
   assign vote  = (c0 & c1) | (c1 & c2) | (c0 & c2);
   assign fault = |((c0 ^ c1) | (c1 ^ c2));

   assign ready = (state == RUN) && (!valid_q || bus.out_ready);
   assign acc   = bus.in_valid && ready;

   // Output register slice: a new accept always overwrites, so accept and
   // drain in the same cycle keeps the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         fault_q <= 1'b0;
      end else if (acc) begin
         valid_q <= 1'b1;
         data_q  <= {vote, vote, vote};
         fault_q <= fault;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Clear has priority over a same-cycle faulty accept; in ALARM no accept
   // can happen, which is what freezes the counter there.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (bus.clear_alarm) begin
         cnt_nx   = '0;
         state_nx = RUN;
      end else if (acc && fault) begin
         cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
         if (cnt_nx >= THRESH) begin
            state_nx = ALARM;
         end
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out_valid  = valid_q;
   assign bus.port_c_out = data_q;
   assign bus.out_fault  = fault_q;
   assign bus.fault_cnt  = cnt;
   assign bus.alarm      = (state == ALARM);

endmodule

`default_nettype wire
